panda_pcap_arm_ctrl: RTL
========================

# panda_pcap_arm_ctrl

Arm/disarm sequencer and capture-readout scheduler for the position-capture datapath. Owns the arm state machine that gates `pcap_enable_o` into `panda_pcap_dsp`. On each accepted `capture_i` pulse from the DSP it snapshots the position bus and streams only the mask-selected fields, one 32-bit word per handshake, to the capture FIFO. Sits between the register block (ARM/DISARM strobes, mask), the DSP and the FIFO.

## Interface
- `NUM_FIELDS`, default 32: number of 32-bit position fields on `posn_i`. Range 1..32.
- `clk_i`  in  1: system clock.
- `reset_n_i`  in  1: asynchronous, active-low reset.
- `ARM`  in  1: one-cycle arm strobe from the register block.
- `DISARM`  in  1: one-cycle disarm strobe.
- `CAPTURE_MASK`  in  NUM_FIELDS: field select. Sampled on an accepted ARM.
- `enable_i`  in  1: external capture enable.
- `capture_i`  in  1: capture pulse from `panda_pcap_dsp` `capture_o`.
- `posn_i`  in  32*NUM_FIELDS: flattened position fields, field k at [32k+31:32k].
- `pcap_enable_o`  out  1: enable to `panda_pcap_dsp`.
- `data_o`  out  32: output word.
- `data_valid_o`  out  1: `data_o` valid.
- `data_ready_i`  in  1: downstream accept.
- `active_o`  out  1: high in ARMED, ACTIVE and DRAIN.
- `capture_count_o`  out  32: number of accepted captures since the last ARM.
- `err_overrun_o`  out  1: sticky overrun flag.

## Operation
- States and transitions:
  - IDLE: on ARM, go to ARMED.
  - ARMED: on `enable_i`=1, go to ACTIVE.
  - ACTIVE: on `enable_i`=0, DISARM or overrun, go to DRAIN.
  - DRAIN: when the scheduler is empty, go to IDLE.
  - DISARM in ARMED goes directly to IDLE.
- Accepted ARM (IDLE only):
  - latches `CAPTURE_MASK`;
  - clears `capture_count_o` and `err_overrun_o`.
- ARM outside IDLE is ignored. ARM and DISARM in the same cycle: DISARM wins, state stays IDLE.
- Capture acceptance:
  - Condition: `capture_i`=1 in ACTIVE while the scheduler is empty.
  - The last handshake of the previous capture in the same cycle counts as empty.
  - Action: snapshot `posn_i` into the shadow register, load the remaining-mask from the latched mask, and increment `capture_count_o`.
  - `capture_count_o` wraps from 0xFFFFFFFF to 0.
- Overrun:
  - Condition: `capture_i`=1 in ACTIVE while the scheduler is busy.
  - Action: the capture is dropped, `err_overrun_o` is set, and the next state is DRAIN.
- Emission:
  - Fields are emitted from the lowest set remaining-mask bit upward.
  - `data_o` = the shadow field, held stable until `data_valid_o` && `data_ready_i`.
  - On each handshake, clear that bit.
- Zero mask: a capture is counted, no words are emitted, and the scheduler stays empty.
- DRAIN never drops a pending word. A capture in progress completes.
- `capture_i` outside ACTIVE is ignored and not counted.

## Timing
- Reset values: state IDLE. `pcap_enable_o`, `data_valid_o`, `active_o` and `err_overrun_o` are 0. `data_o` and `capture_count_o` are 0.
- `pcap_enable_o`:
  - registered, equal to (state==ACTIVE);
  - rises 1 cycle after `enable_i` is sampled high in ARMED;
  - falls 1 cycle after `enable_i` is sampled low.
- First word: `data_valid_o` is high in the cycle after the capture edge (1-cycle latency).
- Throughput: with `data_ready_i` held high, one word per cycle. N set mask bits take N cycles.
- Valid/ready: `data_valid_o` never drops without a handshake. `data_o` changes only after a handshake.
- `capture_count_o` updates the cycle after acceptance. `err_overrun_o` sets the cycle after the overrun.
- Asynchronous reset mid-stream clears the shadow register and mask immediately. No further words are emitted.

## Configuration
- `PCAP_HEADER_EN` defined:
  - every accepted capture first emits a header word = `capture_count_o` value after the increment;
  - the header is followed by the masked fields;
  - a zero mask emits the header only;
  - first-word latency is unchanged, but the word is now the header.
- `PCAP_HEADER_EN` undefined: no header; field words only.

## Structure
- `panda_pcap_pkg`:
  - arm-state enum (IDLE, ARMED, ACTIVE, DRAIN);
  - `PCAP_FIELD_W`=32;
  - `PCAP_MAX_FIELDS`=32.
- Sub-module `panda_pcap_field_sched` contains:
  - the shadow register;
  - the remaining-mask;
  - the lowest-set-bit priority encoder;
  - the valid/ready output stage and the header insertion.
- `panda_pcap_field_sched` exports `sched_empty` and `sched_accept`.
- `panda_pcap_arm_ctrl` holds the FSM, the counter and the error flag.

## Test plan
- ARM with mask 0x00000005, enable_i high, one capture with field0=0x11 and field2=0x33, ready high -> words 0x11 then 0x33 on consecutive cycles; `capture_count_o`=1.
- Same setup with `data_ready_i` low for 5 cycles -> `data_o`=0x11 held with valid high for all 5 cycles; no word lost.
- Mask 0xFFFFFFFF, ready low, second `capture_i` while busy -> `err_overrun_o`=1; state DRAIN; all 32 words of the first capture drain, then IDLE; `capture_count_o`=1.
- Final handshake and new `capture_i` in the same cycle -> no overrun; next capture accepted.
- ARM+DISARM in the same cycle -> stays IDLE; `active_o`=0. DISARM in ACTIVE with 3 words pending -> 3 words emitted, then IDLE; `pcap_enable_o`=0 one cycle after DISARM.
- `PCAP_HEADER_EN` defined, mask 0 -> one header word per capture: 1, 2, 3 for three captures.

Source files
------------

// File: rtl/panda_pcap_pkg.sv
// panda_pcap_pkg: arm-state type, field constants and the lowest-set-bit encoder
// shared by the capture arm/readout path.
package panda_pcap_pkg;

    localparam int PCAP_FIELD_W    = 32;
    localparam int PCAP_MAX_FIELDS = 32;

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DRAIN} arm_state_e;

    // Scans downward so the last hit, and therefore the result, is the lowest set bit.
    function automatic logic [4:0] lowest_set(input logic [PCAP_MAX_FIELDS-1:0] m);
        lowest_set = '0;
        for (int i = PCAP_MAX_FIELDS - 1; i >= 0; i--)
            if (m[i]) lowest_set = 5'(i);
    endfunction

endpackage

// File: rtl/panda_pcap_field_sched.sv
// panda_pcap_field_sched: shadows one capture and streams its mask-selected fields,
// one word per valid/ready handshake; PCAP_HEADER_EN prepends a capture-count header.
module panda_pcap_field_sched
    import panda_pcap_pkg::*;
#(
    parameter int NUM_FIELDS = 32
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               load_i,
    input  logic [NUM_FIELDS-1:0]              mask_i,
    input  logic [PCAP_FIELD_W*NUM_FIELDS-1:0] posn_i,
    input  logic [PCAP_FIELD_W-1:0]            header_i,
    input  logic                               data_ready_i,
    output logic [PCAP_FIELD_W-1:0]            data_o,
    output logic                               data_valid_o,
    output logic                               sched_empty,
    output logic                               sched_accept
);

`ifdef PCAP_HEADER_EN
    localparam logic HDR_EN = 1'b1;
`else
    localparam logic HDR_EN = 1'b0;
`endif

    logic [NUM_FIELDS-1:0][PCAP_FIELD_W-1:0] shadow_q;
    logic [NUM_FIELDS-1:0]                   rem_q, rem_d;
    logic                                    hdr_q, hdr_d;
    logic [PCAP_FIELD_W-1:0]                 hdr_val_q;
    logic [4:0]                              idx;
    logic                                    hs;

    assign idx          = lowest_set(PCAP_MAX_FIELDS'(rem_q));
    assign data_valid_o = hdr_q | (|rem_q);
    assign data_o       = hdr_q ? hdr_val_q : shadow_q[idx];
    assign hs           = data_valid_o & data_ready_i;
    assign sched_empty  = ~data_valid_o;

    // Header goes first; once it is out, each handshake retires the lowest mask bit.
    assign hdr_d        = hdr_q & ~hs;
    assign rem_d        = (hs && !hdr_q) ? rem_q & (rem_q - 1'b1) : rem_q;
    assign sched_accept = ~(hdr_d | (|rem_d));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shadow_q  <= '0;
            rem_q     <= '0;
            hdr_q     <= 1'b0;
            hdr_val_q <= '0;
        end else if (load_i) begin
            shadow_q  <= posn_i;
            rem_q     <= mask_i;
            hdr_q     <= HDR_EN;
            hdr_val_q <= header_i;
        end else begin
            rem_q     <= rem_d;
            hdr_q     <= hdr_d;
        end
    end

endmodule

// File: rtl/panda_pcap_arm_ctrl.sv
// panda_pcap_arm_ctrl: arm/disarm FSM, capture counter and overrun flag in front of the
// field scheduler; define PCAP_HEADER_EN to emit a count header before each capture.
module panda_pcap_arm_ctrl
    import panda_pcap_pkg::*;
#(
    parameter int NUM_FIELDS = 32
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               ARM,
    input  logic                               DISARM,
    input  logic [NUM_FIELDS-1:0]              CAPTURE_MASK,
    input  logic                               enable_i,
    input  logic                               capture_i,
    input  logic [PCAP_FIELD_W*NUM_FIELDS-1:0] posn_i,
    output logic                               pcap_enable_o,
    output logic [PCAP_FIELD_W-1:0]            data_o,
    output logic                               data_valid_o,
    input  logic                               data_ready_i,
    output logic                               active_o,
    output logic [31:0]                        capture_count_o,
    output logic                               err_overrun_o
);

    arm_state_e            state_q, state_d;
    logic                  pen_q;
    logic [NUM_FIELDS-1:0] mask_q;
    logic [31:0]           count_q;
    logic                  err_q;
    logic                  arm_ok, cap_ok, overrun;
    logic                  sched_empty, sched_accept;

    assign arm_ok  = ARM & ~DISARM & (state_q == IDLE);
    assign cap_ok  = capture_i & (state_q == ACTIVE) & sched_accept;
    assign overrun = capture_i & (state_q == ACTIVE) & ~sched_accept;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            pen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pen_q   <= state_d == ACTIVE;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = arm_ok ? ARMED : IDLE;
            ARMED:   state_d = DISARM ? IDLE : enable_i ? ACTIVE : ARMED;
            ACTIVE:  state_d = (!enable_i || DISARM || overrun) ? DRAIN : ACTIVE;
            DRAIN:   state_d = sched_empty ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pcap_enable_o   = pen_q;
        active_o        = state_q != IDLE;
        capture_count_o = count_q;
        err_overrun_o   = err_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mask_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (arm_ok) mask_q <= CAPTURE_MASK;
            count_q <= arm_ok ? '0 : count_q + 32'(cap_ok);
            err_q   <= ~arm_ok & (err_q | overrun);
        end
    end

    panda_pcap_field_sched #(.NUM_FIELDS(NUM_FIELDS)) u_sched (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .load_i       (cap_ok),
        .mask_i       (mask_q),
        .posn_i       (posn_i),
        .header_i     (count_q + 32'd1),
        .data_ready_i (data_ready_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .sched_empty  (sched_empty),
        .sched_accept (sched_accept)
    );

endmodule
